configurable_branch_predictor: RTL and testbench

- Parametrised successor to the fixed-algorithm branch predictor wrapper. It is one predictor core whose algorithm is selected by parameter: bimodal, GAg or gshare.
- Adds multi-lane fetch-group prediction, a speculative global history register (GHR) with a checkpoint per prediction, misprediction recovery, and a sequential PHT initialisation sweep after reset.
- Sits between NextPC (request) and Fetch (response); updates arrive from the branch resolution stage.

---
 rtl/configurable_branch_predictor.sv | 137 +++++++++++++
 tb/tb_configurable_branch_predictor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/configurable_branch_predictor.sv
// Branch predictor core with a parameter-selected index function (bimodal, GAg, gshare),
// multi-lane fetch-group prediction, a speculative GHR with checkpoint recovery and a PHT init sweep.
module configurable_branch_predictor #(
    parameter int unsigned MODE        = 2,
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned PHT_ENTRIES = 1024,
    parameter int unsigned GHR_WIDTH   = 10,
    parameter int unsigned PC_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   reqValid,
    input  logic [PC_WIDTH-1:0]    reqPC,
    input  logic [FETCH_WIDTH-1:0] reqIsBranch,
    output logic                   predValid,
    output logic [FETCH_WIDTH-1:0] predTaken,
    output logic [GHR_WIDTH-1:0]   predHist,
    input  logic                   updValid,
    input  logic [PC_WIDTH-1:0]    updPC,
    input  logic [GHR_WIDTH-1:0]   updHist,
    input  logic                   updTaken,
    input  logic                   updMispred,
    output logic                   initBusy
);

    localparam int unsigned IDX = $clog2(PHT_ENTRIES);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e               state_q;
    logic [IDX-1:0]       init_idx_q;
    logic [GHR_WIDTH-1:0] ghr_q;
    logic [1:0]           pht_q [PHT_ENTRIES];

    logic [IDX-1:0]         rd_idx [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] taken_raw;
    logic                   spec_bit;
    logic                   recover;
    logic [IDX-1:0]         upd_idx;
    logic [1:0]             upd_ctr;
    logic                   wr_en;
    logic [IDX-1:0]         wr_idx;
    logic [1:0]             wr_data;

    // pcw is the word index of the lane PC; lane offsets never carry out of the IDX window.
    function automatic logic [IDX-1:0] pht_index(input logic [IDX-1:0] pcw,
                                                 input logic [GHR_WIDTH-1:0] hist,
                                                 input logic [IDX-1:0] lane);
        logic [IDX-1:0] h;
        h = IDX'(hist);
        if (MODE == 0) begin
            return pcw;
        end else if (MODE == 1) begin
            return h + lane;
        end else begin
            return pcw ^ h;
        end
    endfunction

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            rd_idx[i]    = pht_index(reqPC[IDX+1:2] + IDX'(i), ghr_q, IDX'(i));
            taken_raw[i] = pht_q[rd_idx[i]][1] & reqIsBranch[i];
        end
    end

    assign spec_bit = |taken_raw;
    assign recover  = (state_q == StRun) && updValid && updMispred;
    assign upd_idx  = pht_index(updPC[IDX+1:2], updHist, '0);
    assign upd_ctr  = pht_q[upd_idx];

    // Single write port: the sweep owns it during init, resolved updates afterwards.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = init_idx_q;
        wr_data = 2'b01;
        if (state_q == StInit) begin
            wr_en = 1'b1;
        end else if (updValid) begin
            wr_en  = 1'b1;
            wr_idx = upd_idx;
            if (updTaken) begin
                wr_data = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'b01;
            end else begin
                wr_data = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pht_q[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StInit;
            init_idx_q <= '0;
            ghr_q      <= '0;
            predValid  <= 1'b0;
            predTaken  <= '0;
            predHist   <= '0;
            initBusy   <= 1'b1;
        end else begin
            predValid <= 1'b0;
            predTaken <= '0;
            unique case (state_q)
                StInit: begin
                    init_idx_q <= init_idx_q + 1'b1;
                    if (init_idx_q == IDX'(PHT_ENTRIES - 1)) begin
                        state_q  <= StRun;
                        initBusy <= 1'b0;
                    end
                end
                StRun: begin
                    // A request colliding with a recovery is squashed.
                    if (reqValid && !recover) begin
                        predValid <= 1'b1;
                        predTaken <= taken_raw;
                        predHist  <= ghr_q;
                    end
                    if (recover) begin
                        ghr_q <= {updHist[GHR_WIDTH-2:0], updTaken};
                    end else if (reqValid && |reqIsBranch) begin
                        ghr_q <= {ghr_q[GHR_WIDTH-2:0], spec_bit};
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    logic unused_pc;
    assign unused_pc = ^{reqPC[PC_WIDTH-1:IDX+2], reqPC[1:0], updPC[PC_WIDTH-1:IDX+2], updPC[1:0]};

endmodule

// File: tb/tb_configurable_branch_predictor.sv
// Scoreboard bench: a gshare and a bimodal instance share stimulus; a select gates valids.
module tb_configurable_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reqValid = 1'b0;
    logic [31:0] reqPC = '0;
    logic [1:0]  reqIsBranch = '0;
    logic        updValid = 1'b0;
    logic [31:0] updPC = '0;
    logic [9:0]  updHist = '0;
    logic        updTaken = 1'b0;
    logic        updMispred = 1'b0;
    bit          sel = 1'b0;

    logic       pv_g, pv_b, ib_g, ib_b;
    logic [1:0] pt_g, pt_b;
    logic [9:0] ph_g, ph_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] q_g[$];
    logic [11:0] q_b[$];

    always #5 clk = ~clk;

    configurable_branch_predictor #(.MODE(2)) dut_g (
        .clk(clk), .rst(rst),
        .reqValid(reqValid & ~sel), .reqPC(reqPC), .reqIsBranch(reqIsBranch),
        .predValid(pv_g), .predTaken(pt_g), .predHist(ph_g),
        .updValid(updValid & ~sel), .updPC(updPC), .updHist(updHist),
        .updTaken(updTaken), .updMispred(updMispred), .initBusy(ib_g)
    );

    configurable_branch_predictor #(.MODE(0)) dut_b (
        .clk(clk), .rst(rst),
        .reqValid(reqValid & sel), .reqPC(reqPC), .reqIsBranch(reqIsBranch),
        .predValid(pv_b), .predTaken(pt_b), .predHist(ph_b),
        .updValid(updValid & sel), .updPC(updPC), .updHist(updHist),
        .updTaken(updTaken), .updMispred(updMispred), .initBusy(ib_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && pv_g) begin
            if (q_g.size() == 0) begin
                check("gshare_unexpected_pred", 32'(pv_g), 32'(0));
            end else begin
                logic [11:0] e;
                e = q_g.pop_front();
                check("gshare_taken", 32'(pt_g), 32'(e[11:10]));
                check("gshare_hist", 32'(ph_g), 32'(e[9:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && pv_b) begin
            if (q_b.size() == 0) begin
                check("bimodal_unexpected_pred", 32'(pv_b), 32'(0));
            end else begin
                logic [11:0] e;
                e = q_b.pop_front();
                check("bimodal_taken", 32'(pt_b), 32'(e[11:10]));
                check("bimodal_hist", 32'(ph_b), 32'(e[9:0]));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit s, input logic [31:0] pc, input logic [1:0] br,
                          input logic [1:0] exp_t, input logic [9:0] exp_h);
        sel = s;
        reqValid = 1'b1;
        reqPC = pc;
        reqIsBranch = br;
        if (s) q_b.push_back({exp_t, exp_h});
        else q_g.push_back({exp_t, exp_h});
        cycle();
        reqValid = 1'b0;
    endtask

    task automatic do_upd(input bit s, input logic [31:0] pc, input logic [9:0] hist,
                          input logic taken, input logic mis);
        sel = s;
        updValid = 1'b1;
        updPC = pc;
        updHist = hist;
        updTaken = taken;
        updMispred = mis;
        cycle();
        updValid = 1'b0;
        updMispred = 1'b0;
    endtask

    task automatic wait_init(input string name, input int start);
        int n;
        n = start;
        while (ib_g && n < 2000) begin
            cycle();
            n++;
        end
        check(name, 32'(n), 32'd1024);
        check({name, "_bimodal_done"}, 32'(ib_b), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) cycle();
        check("reset_initbusy", 32'(ib_g), 32'd1);
        check("reset_predvalid", 32'(pv_g), 32'd0);
        check("reset_predtaken", 32'(pt_g), 32'd0);
        check("reset_predhist", 32'(ph_g), 32'd0);
        rst = 1'b1;
        // Mispredict during the sweep must be dropped: GHR stays 0.
        sel = 1'b0;
        updValid = 1'b1; updPC = 32'h0; updHist = 10'h155; updTaken = 1'b1; updMispred = 1'b1;
        cycle();
        updValid = 1'b0; updMispred = 1'b0;
        check("init_no_pred", 32'(pv_g), 32'd0);
        wait_init("init_sweep_cycles", 1);

        do_req(1'b0, 32'h0, 2'b01, 2'b00, 10'h000);

        // Bimodal saturation at both ends.
        repeat (3) do_upd(1'b1, 32'h100, 10'h0, 1'b1, 1'b0);
        do_req(1'b1, 32'h100, 2'b11, 2'b01, 10'h000);
        repeat (4) do_upd(1'b1, 32'h100, 10'h0, 1'b0, 1'b0);
        do_upd(1'b1, 32'h100, 10'h0, 1'b1, 1'b0);
        do_req(1'b1, 32'h100, 2'b01, 2'b00, 10'h001);
        do_req(1'b1, 32'h100, 2'b00, 2'b00, 10'h002);

        // Gshare: preload PHT[7] = 3, recover GHR to 0x003.
        repeat (2) do_upd(1'b0, 32'h10, 10'h003, 1'b1, 1'b0);
        do_upd(1'b0, 32'h200, 10'h001, 1'b1, 1'b1);
        do_req(1'b0, 32'h10, 2'b01, 2'b01, 10'h003);
        do_req(1'b0, 32'h0, 2'b00, 2'b00, 10'h007);

        // Recovery colliding with a request: squashed, no speculative shift.
        sel = 1'b0;
        reqValid = 1'b1; reqPC = 32'h10; reqIsBranch = 2'b01;
        updValid = 1'b1; updPC = 32'h300; updHist = 10'h155; updTaken = 1'b0; updMispred = 1'b1;
        cycle();
        reqValid = 1'b0; updValid = 1'b0; updMispred = 1'b0;
        check("squash_predvalid", 32'(pv_g), 32'd0);
        do_req(1'b0, 32'h0, 2'b00, 2'b00, 10'h2AA);

        // Same-cycle update and request to index 0x2A2: no forwarding.
        sel = 1'b0;
        updValid = 1'b1; updPC = 32'h20; updHist = 10'h2AA; updTaken = 1'b1; updMispred = 1'b0;
        do_req(1'b0, 32'h20, 2'b01, 2'b00, 10'h2AA);
        updValid = 1'b0;
        do_req(1'b0, 32'hFD8, 2'b01, 2'b01, 10'h154);
        do_req(1'b0, 32'hAB4, 2'b11, 2'b10, 10'h2A9);
        do_req(1'b0, 32'h0, 2'b00, 2'b00, 10'h153);

        repeat (3) cycle();
        check("queue_g_drained", 32'(q_g.size()), 32'd0);
        check("queue_b_drained", 32'(q_b.size()), 32'd0);

        // Reset mid-sweep at initIdx = 500.
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        repeat (500) cycle();
        check("midsweep_busy", 32'(ib_g), 32'd1);
        rst = 1'b0;
        cycle();
        check("midsweep_reset_busy", 32'(ib_g), 32'd1);
        rst = 1'b1;
        sel = 1'b0;
        reqValid = 1'b1; reqPC = 32'h1C; reqIsBranch = 2'b01;
        cycle();
        reqValid = 1'b0;
        check("midsweep_no_pred", 32'(pv_g), 32'd0);
        wait_init("resweep_cycles", 1);
        do_req(1'b0, 32'h1C, 2'b01, 2'b00, 10'h000);

        repeat (3) cycle();
        check("queue_g_final", 32'(q_g.size()), 32'd0);
        check("queue_b_final", 32'(q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
